// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
//   Constants shared by the memory-access pipeline stage and its neighbours:
//   exception-flag bit positions, load_op bit positions, the 65-bit multiplier
//   result width and the widths of every inter-stage bus.
//
//   Bus widths depend on the exception-vector width, so they are provided both
//   as helper functions (for parameterised instances) and as localparams
//   evaluated at the default EXC_NUM.
// -----------------------------------------------------------------------------
package mem_stage_pkg;

  // Width of the exception-flag vector: {ADEF, ALE, BRK, INE, INT, SYS}.
  localparam int EXC_NUM = 6;

  // Bit positions inside exc_flgs (MSB first as listed above).
  localparam int EXC_FLG_SYS  = 0;
  localparam int EXC_FLG_INT  = 1;
  localparam int EXC_FLG_INE  = 2;
  localparam int EXC_FLG_BRK  = 3;
  localparam int EXC_FLG_ALE  = 4;
  localparam int EXC_FLG_ADEF = 5;

  // Bit positions inside the one-hot load_op field.
  localparam int LOAD_OP_HU = 0;  // ld.hu, zero-extended halfword
  localparam int LOAD_OP_BU = 1;  // ld.bu, zero-extended byte
  localparam int LOAD_OP_W  = 2;  // ld.w,  whole word
  localparam int LOAD_OP_H  = 3;  // ld.h,  sign-extended halfword
  localparam int LOAD_OP_B  = 4;  // ld.b,  sign-extended byte

  // Multiplier side-band: bit 64 picks the high word, [63:0] is the product.
  localparam int MUL_RES_W  = 65;
  localparam int MUL_HI_BIT = 64;

  // {rdcn_en, rdcn_sel, csr_we, csr_wnum[13:0], csr_wmask[31:0],
  //  csr_wdata[31:0], ertn, exc_flgs, res_from_mul, load_op[4:0], gr_we,
  //  dest[4:0], result[31:0], pc[31:0]}
  function automatic int es_to_ms_w(input int exc_num);
    return 158 + exc_num;
  endfunction

  // {csr_we, csr_wnum[13:0], csr_wmask[31:0], csr_wdata[31:0], ertn,
  //  exc_flgs, badv[31:0], gr_we, dest[4:0], final_result[31:0], pc[31:0]}
  function automatic int ms_to_ws_w(input int exc_num);
    return 182 + exc_num;
  endfunction

  localparam int ES_TO_MS_BUS_WD   = es_to_ms_w(EXC_NUM);
  localparam int MS_TO_WS_BUS_WD   = ms_to_ws_w(EXC_NUM);
  // {gr_we_v, dest[4:0], final_result[31:0]}
  localparam int MS_FWD_BLK_BUS_WD = 38;
  // {csr_we_v, ertn_v, csr_wnum[13:0]}
  localparam int MS_CSR_BLK_BUS_WD = 16;

endpackage

// File: rtl/mem_stage_load_align.sv
// -----------------------------------------------------------------------------
// ms_load_align
//   Extracts the addressed byte / halfword from a 32-bit SRAM read word and
//   zero- or sign-extends it according to the one-hot load_op.
//
//   Ports
//     rdata   [31:0] in   raw word returned by the data SRAM
//     addr    [1:0]  in   low address bits of the load
//     load_op [4:0]  in   {ld.b, ld.h, ld.w, ld.bu, ld.hu}
//     data    [31:0] out  aligned, extended load value (0 when no load bit set)
// -----------------------------------------------------------------------------
module ms_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [4:0]  load_op,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
  end

  // Halfword loads are naturally aligned, so only addr[1] matters.
  assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

  // load_op is one-hot in normal use; the fixed priority only keeps the
  // result deterministic if a malformed multi-hot value ever arrives.
  always_comb begin
    data = 32'h0;
    if (load_op[LOAD_OP_B]) begin
      data = {{24{byte_sel[7]}}, byte_sel};
    end else if (load_op[LOAD_OP_BU]) begin
      data = {24'h0, byte_sel};
    end else if (load_op[LOAD_OP_H]) begin
      data = {{16{half_sel[15]}}, half_sel};
    end else if (load_op[LOAD_OP_HU]) begin
      data = {16'h0, half_sel};
    end else if (load_op[LOAD_OP_W]) begin
      data = rdata;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//   Memory-access stage of the five-stage pipeline. Holds one instruction,
//   merges the synchronous data-SRAM read word (for loads) or the multiplier
//   product into final_result, and hands the result to write-back.
//
//   Ports
//     clk, resetn           clock, asynchronous active-low reset
//     es_to_ms_valid/bus    instruction arriving from EXE
//     ms_allowin            MEM can accept a new instruction this cycle
//     es_mul_res_bus [64:0] {select_high, product[63:0]} from the multiplier
//     data_sram_rdata       read word for the load currently held in MEM
//     ws_allowin            WB can accept
//     ms_to_ws_valid/bus    instruction leaving for WB
//     wb_exc, wb_ertn       flush from WB (exception taken / ertn retired)
//     ms_to_es_st_cancel    tells EXE to suppress younger stores
//     ms_fwd_blk_bus        {gr_we_v, dest, final_result} for bypass
//     ms_csr_blk_bus        {csr_we_v, ertn_v, csr_wnum} for CSR hazards
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int EXC_NUM = mem_stage_pkg::EXC_NUM
) (
  input  logic                                           clk,
  input  logic                                           resetn,
  input  logic                                           es_to_ms_valid,
  output logic                                           ms_allowin,
  input  logic [mem_stage_pkg::es_to_ms_w(EXC_NUM)-1:0]  es_to_ms_bus,
  input  logic [mem_stage_pkg::MUL_RES_W-1:0]            es_mul_res_bus,
  input  logic [31:0]                                    data_sram_rdata,
  input  logic                                           ws_allowin,
  output logic                                           ms_to_ws_valid,
  output logic [mem_stage_pkg::ms_to_ws_w(EXC_NUM)-1:0]  ms_to_ws_bus,
  input  logic                                           wb_exc,
  input  logic                                           wb_ertn,
  output logic                                           ms_to_es_st_cancel,
  output logic [mem_stage_pkg::MS_FWD_BLK_BUS_WD-1:0]    ms_fwd_blk_bus,
  output logic [mem_stage_pkg::MS_CSR_BLK_BUS_WD-1:0]    ms_csr_blk_bus
);

  import mem_stage_pkg::*;

  localparam int ESW = es_to_ms_w(EXC_NUM);

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  logic                 ms_valid_q, ms_valid_d;
  logic [ESW-1:0]       es_bus_q, es_bus_d;
  logic [MUL_RES_W-1:0] mul_res_q, mul_res_d;

  logic ms_ready_go;
  logic flush;
  logic capture;

  // Data arrives from the SRAM in the cycle the load sits here, so MEM never
  // needs an extra cycle.
  assign ms_ready_go    = 1'b1;
  assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid_q && ms_ready_go;

  assign flush   = wb_exc | wb_ertn;
  assign capture = es_to_ms_valid && ms_allowin;

  always_comb begin
    ms_valid_d = ms_valid_q;
    es_bus_d   = es_bus_q;
    mul_res_d  = mul_res_q;
    // A flush wins over a same-cycle capture: the arriving instruction is
    // younger than the one that trapped.
    if (flush) begin
      ms_valid_d = 1'b0;
    end else if (ms_allowin) begin
      ms_valid_d = es_to_ms_valid;
    end
    if (capture) begin
      es_bus_d  = es_to_ms_bus;
      mul_res_d = es_mul_res_bus;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid_q <= 1'b0;
      es_bus_q   <= '0;
      mul_res_q  <= '0;
    end else begin
      ms_valid_q <= ms_valid_d;
      es_bus_q   <= es_bus_d;
      mul_res_q  <= mul_res_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Unpack the held instruction
  // ---------------------------------------------------------------------------
  logic               rdcn_en;
  logic               rdcn_sel;
  logic               csr_we;
  logic [13:0]        csr_wnum;
  logic [31:0]        csr_wmask;
  logic [31:0]        csr_wdata;
  logic               ertn;
  logic [EXC_NUM-1:0] exc_flgs;
  logic               res_from_mul;
  logic [4:0]         load_op;
  logic               gr_we;
  logic [4:0]         dest;
  logic [31:0]        result;
  logic [31:0]        pc;

  assign {rdcn_en, rdcn_sel, csr_we, csr_wnum, csr_wmask, csr_wdata, ertn,
          exc_flgs, res_from_mul, load_op, gr_we, dest, result, pc} = es_bus_q;

  // The counter-read controls were consumed in EXE; they only ride along.
  logic unused_rdcn;
  assign unused_rdcn = rdcn_en ^ rdcn_sel;

  // ---------------------------------------------------------------------------
  // Result selection
  // ---------------------------------------------------------------------------
  logic [31:0] load_data;
  logic [31:0] mul_word;
  logic [31:0] final_result;
  logic        has_exc;
  logic [31:0] badv;
  logic        ws_gr_we;

  ms_load_align u_load_align (
    .rdata   (data_sram_rdata),
    .addr    (result[1:0]),
    .load_op (load_op),
    .data    (load_data)
  );

  assign mul_word = mul_res_q[MUL_HI_BIT] ? mul_res_q[63:32] : mul_res_q[31:0];

  always_comb begin
    final_result = result;
    if (|load_op) begin
      final_result = load_data;
    end else if (res_from_mul) begin
      final_result = mul_word;
    end
  end

  assign has_exc = |exc_flgs;

  // Address faults report the data/fetch address in result; every other
  // exception reports the instruction's own pc.
  assign badv = (exc_flgs[EXC_FLG_ALE] || exc_flgs[EXC_FLG_ADEF]) ? result : pc;

  // A faulting instruction must not retire a register write.
  assign ws_gr_we = gr_we && !has_exc;

  assign ms_to_ws_bus = {csr_we, csr_wnum, csr_wmask, csr_wdata, ertn,
                         exc_flgs, badv, ws_gr_we, dest, final_result, pc};

  // ---------------------------------------------------------------------------
  // Hazard / control side-band
  // ---------------------------------------------------------------------------
  // Anything here that will redirect the pipeline means younger stores in EXE
  // must not reach memory.
  assign ms_to_es_st_cancel = ms_valid_q && (has_exc || ertn);

  // Load data is already aligned this cycle, so the bypass never has to stall.
  assign ms_fwd_blk_bus = {ms_valid_q && gr_we, dest, final_result};
  assign ms_csr_blk_bus = {ms_valid_q && csr_we, ms_valid_q && ertn, csr_wnum};

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter EXC_NUM, default 6, meaning the width of the exception-flag vector (ADEF, ALE, BRK, INE, INT, SYS).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have ports es_to_ms_valid (input, 1) and ms_allowin (output, 1): the upstream handshake.
REQ-005 SHALL have port es_to_ms_bus, input: {rdcn_en, rdcn_sel, csr_we, csr_wnum[13:0], csr_wmask[31:0], csr_wdata[31:0], ertn, exc_flgs[EXC_NUM-1:0], res_from_mul, load_op[4:0], gr_we, dest[4:0], result[31:0], pc[31:0]}, MSB first.
REQ-006 SHALL have ports es_mul_res_bus (input, 65 bits: bit64 selects the high word, [63:0] is the product) and data_sram_rdata (input, 32 bits).
REQ-007 SHALL have ports ws_allowin (input, 1), ms_to_ws_valid (output, 1) and ms_to_ws_bus (output): {csr_we, csr_wnum, csr_wmask, csr_wdata, ertn, exc_flgs, badv[31:0], gr_we, dest, final_result[31:0], pc}.
REQ-008 SHALL have inputs wb_exc and wb_ertn, 1 bit each: pipeline flush.
REQ-009 SHALL have outputs ms_to_es_st_cancel (1), ms_fwd_blk_bus ({gr_we_v, dest[4:0], final_result[31:0]}) and ms_csr_blk_bus ({csr_we_v, ertn_v, csr_wnum[13:0]}).

Function
REQ-010 SHALL hold ms_valid and a bus register; ms_ready_go is 1; ms_allowin = !ms_valid || ws_allowin; ms_to_ws_valid = ms_valid.
REQ-011 SHALL, on a clock edge with wb_exc|wb_ertn, clear ms_valid, overriding any capture in the same cycle.
REQ-012 SHALL otherwise, when ms_allowin, load ms_valid <= es_to_ms_valid; the bus register and the 65-bit mul register load only when es_to_ms_valid && ms_allowin.
REQ-013 SHALL treat data_sram_rdata as belonging to the instruction now in MEM (synchronous SRAM, issued the previous cycle); no internal data buffering.
REQ-014 SHALL select the load byte with result[1:0] and the halfword with result[1].
REQ-015 SHALL apply load_op as follows: [4] ld.b sign-extend, [1] ld.bu zero-extend, [3] ld.h sign-extend, [0] ld.hu zero-extend, [2] ld.w whole word.
REQ-016 SHALL compute final_result in priority order: any load_op bit -> load data; res_from_mul -> product[63:32] if bit64 else product[31:0]; else result.
REQ-017 SHALL set badv = result when exc_flgs ALE or ADEF is set, else pc.
REQ-018 SHALL clear gr_we in ms_to_ws_bus when any exc_flgs bit is set.
REQ-019 SHALL drive ms_to_es_st_cancel = ms_valid & ((|exc_flgs) | ertn).
REQ-020 SHALL qualify gr_we_v, csr_we_v and ertn_v with ms_valid.
REQ-021 SHALL forward final_result combinationally in the same cycle; it never asserts a load-use block, since the load data is available.

Reset
REQ-022 SHALL, while resetn=0, asynchronously clear ms_valid, the bus register and the mul register to 0; all valid-qualified outputs are then 0.
REQ-023 SHALL, if reset asserts mid-operation, drop the in-flight instruction; the first capture occurs on the first edge with resetn=1.

Structure
REQ-024 SHALL take the EXC_FLG_* bit indices, EXC_NUM and the ES_TO_MS/MS_TO_WS/fwd/blk bus widths from the shared mycpu.h package.
REQ-025 SHALL place the load alignment and extension in one sub-module, ms_load_align (inputs rdata, addr[1:0], load_op; output 32-bit data).

Verification
REQ-026 SHALL cover: ld.b at addr 0x...3 with rdata 0x80FF_1234 -> final_result 0xFFFF_FF80; ld.bu -> 0x0000_0080.
REQ-027 SHALL cover: ld.h at addr 0x...2 with rdata 0x8001_7FFF -> 0xFFFF_8001; ld.hu -> 0x0000_8001; ld.w -> 0x8001_7FFF.
REQ-028 SHALL cover: mul with product 0x0000_0002_0000_0003 and bit64=1 -> final_result 0x0000_0002, and fwd gr_we_v=1.
REQ-029 SHALL cover: ALE flag set on a load at 0x1001 -> ms_to_es_st_cancel=1, badv=0x0000_1001, gr_we=0 in ms_to_ws_bus.
REQ-030 SHALL cover: ws_allowin=0 for 3 cycles -> the bus is held stable and ms_allowin=0; a wb_exc pulse while stalled -> ms_valid=0 on the next edge.
REQ-031 SHALL cover: resetn low mid-stream -> ms_valid falls immediately, without waiting for a clock edge.
